// File: rtl/axis_pkt_checker_pkg.sv
// Shared types and constants for the AXI4-Stream packet checker and related sinks.
package axis_pkt_checker_pkg;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_FIRST = 2'd1,
        ST_PAY   = 2'd2,
        ST_DRAIN = 2'd3
    } pkt_state_t;

    localparam int DEFAULT_KEEP_W = 64;
    localparam int STAT_W         = 64;
    localparam int ERR_CNT_W      = 32;
    localparam int BEAT_IDX_W     = 16;
    localparam int SEQ_W          = 64;

    localparam int ERR_SEQ  = 0;
    localparam int ERR_KEEP = 1;
    localparam int ERR_LEN  = 2;
    localparam int NUM_ERR  = 3;

    function automatic logic [1:0] count_errs(input logic [NUM_ERR-1:0] e);
        return {1'b0, e[ERR_SEQ]} + {1'b0, e[ERR_KEEP]} + {1'b0, e[ERR_LEN]};
    endfunction

endpackage

// File: rtl/axis_pkt_checker_keep_check.sv
// Combinational tkeep analysis: byte popcount, all-ones test and last-beat
// validity (non-zero and contiguous from the LSB).
module axis_keep_check #(
    parameter int KEEP_W = 64,
    parameter int POP_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] tkeep,
    output logic [POP_W-1:0]  popcount,
    output logic              all_ones,
    output logic              last_ok
);

    always_comb begin
        popcount = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            popcount = popcount + POP_W'(tkeep[i]);
        end
    end

    assign all_ones = &tkeep;
    // A mask of the form 0..01..1 has no bit in common with itself plus one.
    assign last_ok  = (tkeep != '0) && ((tkeep & (tkeep + KEEP_W'(1))) == '0);

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that applies programmable backpressure, checks header/
// incrementing-payload packets for sequence, tkeep and length, and keeps stats.
module axis_pkt_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAX_PKT_BEATS        = 64
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              enable,
    input  logic [7:0]                        cfg_ready_pattern,
    input  logic [15:0]                       cfg_expect_beats,
    input  logic                              err_clear,
    output logic [STAT_W-1:0]                 pkt_count,
    output logic [STAT_W-1:0]                 beat_count,
    output logic [STAT_W-1:0]                 byte_count,
    output logic [ERR_CNT_W-1:0]              err_count,
    output logic                              err_seq,
    output logic                              err_keep,
    output logic                              err_len
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int POP_W  = $clog2(KEEP_W + 1);

    logic [2:0]            ptr;
    logic                  ready_q;
    logic                  accept;
    pkt_state_t            state_q, state_d;
    logic [SEQ_W-1:0]      exp_seq_q, exp_seq_d;
    logic [BEAT_IDX_W-1:0] beat_idx_q, beat_idx_d, idx_cur;
    logic                  overrun;
    logic [NUM_ERR-1:0]    new_err;
    logic [1:0]            new_err_n;
    logic [ERR_CNT_W:0]    err_sum;
    logic [POP_W-1:0]      keep_pop;
    logic                  keep_full;
    logic                  keep_last_ok;
    logic                  unused_inputs;

    assign unused_inputs = ^{s_axis_tuser, s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:SEQ_W]};

    axis_keep_check #(
        .KEEP_W (KEEP_W),
        .POP_W  (POP_W)
    ) u_keep_check (
        .tkeep    (s_axis_tkeep),
        .popcount (keep_pop),
        .all_ones (keep_full),
        .last_ok  (keep_last_ok)
    );

    // Gating with enable directly lets a disable freeze the stream at once.
    assign s_axis_tready = ready_q & enable;
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ptr     <= '0;
            ready_q <= 1'b0;
        end else if (enable) begin
            ready_q <= cfg_ready_pattern[ptr];
            ptr     <= ptr + 3'd1;
        end else begin
            ready_q <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_seq_d  = exp_seq_q;
        beat_idx_d = beat_idx_q;
        new_err    = '0;
        idx_cur    = (state_q == ST_HDR) ? BEAT_IDX_W'(1) : beat_idx_q + BEAT_IDX_W'(1);
        overrun    = !s_axis_tlast && (idx_cur == BEAT_IDX_W'(MAX_PKT_BEATS));
        if (accept) begin
            beat_idx_d = idx_cur;
            if (state_q != ST_DRAIN) begin
                new_err[ERR_KEEP] = s_axis_tlast ? !keep_last_ok : !keep_full;
                new_err[ERR_SEQ]  = (state_q == ST_PAY) && (s_axis_tdata[SEQ_W-1:0] != exp_seq_q);
                new_err[ERR_LEN]  = overrun ||
                                    (s_axis_tlast && (cfg_expect_beats != 16'd0) &&
                                     (idx_cur != cfg_expect_beats));
            end
            case (state_q)
                ST_HDR: begin
                    state_d = s_axis_tlast ? ST_HDR : (overrun ? ST_DRAIN : ST_FIRST);
                end
                ST_FIRST: begin
                    exp_seq_d = s_axis_tdata[SEQ_W-1:0] + SEQ_W'(1);
                    state_d   = s_axis_tlast ? ST_HDR : (overrun ? ST_DRAIN : ST_PAY);
                end
                ST_PAY: begin
                    exp_seq_d = exp_seq_q + SEQ_W'(1);
                    state_d   = s_axis_tlast ? ST_HDR : (overrun ? ST_DRAIN : ST_PAY);
                end
                ST_DRAIN: begin
                    beat_idx_d = beat_idx_q;
                    if (s_axis_tlast) begin
                        state_d = ST_HDR;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
        new_err_n = count_errs(new_err);
        err_sum   = {1'b0, err_count} + (ERR_CNT_W + 1)'(new_err_n);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= ST_HDR;
            exp_seq_q  <= '0;
            beat_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_seq_q  <= exp_seq_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    // A clear coinciding with a new error keeps the new error.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            pkt_count  <= '0;
            beat_count <= '0;
            byte_count <= '0;
            err_count  <= '0;
            err_seq    <= 1'b0;
            err_keep   <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            if (accept) begin
                beat_count <= beat_count + STAT_W'(1);
                byte_count <= byte_count + STAT_W'(keep_pop);
                if (s_axis_tlast) begin
                    pkt_count <= pkt_count + STAT_W'(1);
                end
            end
            if (err_clear) begin
                err_count <= ERR_CNT_W'(new_err_n);
            end else if (err_sum[ERR_CNT_W]) begin
                err_count <= '1;
            end else begin
                err_count <= err_sum[ERR_CNT_W-1:0];
            end
            err_seq  <= (err_seq  & ~err_clear) | new_err[ERR_SEQ];
            err_keep <= (err_keep & ~err_clear) | new_err[ERR_KEEP];
            err_len  <= (err_len  & ~err_clear) | new_err[ERR_LEN];
        end
    end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed, table-driven bench for axis_pkt_checker with hand-written
// sequences for backpressure, overrun/drain, enable pause and reset.
module tb_axis_pkt_checker;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 128;
    localparam logic [63:0] HDR   = 64'hDEAD_BEEF_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K0F   = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] K0FF  = 64'h0FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KLOW8 = 64'h0000_0000_0000_00FF;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          enable;
    logic [7:0]    cfg_ready_pattern;
    logic [15:0]   cfg_expect_beats;
    logic          err_clear;
    logic [63:0]   pkt_count, beat_count, byte_count;
    logic [31:0]   err_count;
    logic          err_seq, err_keep, err_len;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_beats = 0;
    logic [63:0]   exp_bytes = 0;

    typedef struct {
        logic [63:0] seq;
        logic [63:0] keep;
        logic        last;
        logic        clr;
        logic        chk;
        logic        e_seq;
        logic        e_keep;
        logic        e_len;
        logic [31:0] e_cnt;
        logic [63:0] e_pkt;
    } vec_t;

    vec_t vecs[$];

    axis_pkt_checker #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .MAX_PKT_BEATS        (8)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .enable            (enable),
        .cfg_ready_pattern (cfg_ready_pattern),
        .cfg_expect_beats  (cfg_expect_beats),
        .err_clear         (err_clear),
        .pkt_count         (pkt_count),
        .beat_count        (beat_count),
        .byte_count        (byte_count),
        .err_count         (err_count),
        .err_seq           (err_seq),
        .err_keep          (err_keep),
        .err_len           (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t v(input logic [63:0] seq, input logic [63:0] keep,
                               input logic last, input logic clr, input logic chk,
                               input logic es, input logic ek, input logic el,
                               input logic [31:0] ec, input logic [63:0] ep);
        vec_t r;
        r.seq = seq;  r.keep = keep; r.last = last; r.clr = clr; r.chk = chk;
        r.e_seq = es; r.e_keep = ek; r.e_len = el;  r.e_cnt = ec; r.e_pkt = ep;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents one beat and holds it until a handshake, bounded by a cycle budget.
    task automatic sendBeat(input logic [63:0] seq, input logic [63:0] keep,
                            input logic last, input logic clr);
        int budget = 0;
        @(negedge clk);
        s_axis_tdata       = '0;
        s_axis_tdata[63:0] = seq;
        s_axis_tkeep       = keep;
        s_axis_tlast       = last;
        s_axis_tvalid      = 1'b1;
        err_clear          = clr;
        while (!s_axis_tready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got no tready expected tready within 100 cycles");
        end else begin
            exp_beats = exp_beats + 64'd1;
            exp_bytes = exp_bytes + 64'($countones(keep));
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        err_clear     = 1'b0;
    endtask

    task automatic sendPkt(input logic [63:0] first, input int n_pay);
        sendBeat(HDR, ONES, (n_pay == 0), 1'b0);
        for (int i = 0; i < n_pay; i++) begin
            sendBeat(first + 64'(i), ONES, (i == n_pay - 1), 1'b0);
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        if (r.clr) begin
            @(negedge clk);
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
        end
        sendBeat(r.seq, r.keep, r.last, 1'b0);
    endtask

    task automatic checkStats(input string tag);
        @(negedge clk);
        checkOutput({tag, "_beats"}, beat_count, exp_beats);
        checkOutput({tag, "_bytes"}, byte_count, exp_bytes);
    endtask

    initial begin
        int highs;
        int toggles;
        logic prev;

        aresetn           = 1'b0;
        s_axis_tdata      = '0;
        s_axis_tkeep      = '0;
        s_axis_tuser      = {UW{1'b1}};
        s_axis_tvalid     = 1'b0;
        s_axis_tlast      = 1'b0;
        enable            = 1'b0;
        cfg_ready_pattern = 8'hFF;
        cfg_expect_beats  = 16'd4;
        err_clear         = 1'b0;
        repeat (4) @(negedge clk);

        checkOutput("rst_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("rst_pkt", pkt_count, 64'd0);
        checkOutput("rst_beat", beat_count, 64'd0);
        checkOutput("rst_byte", byte_count, 64'd0);
        checkOutput("rst_errcnt", 64'(err_count), 64'd0);
        checkOutput("rst_flags", 64'({err_seq, err_keep, err_len}), 64'd0);

        aresetn = 1'b1;
        enable  = 1'b1;

        $display("[TB] test 1: full rate, 10 packets");
        for (int p = 0; p < 10; p++) sendPkt(64'd2, 3);
        @(negedge clk);
        checkOutput("t1_pkt", pkt_count, 64'd10);
        checkOutput("t1_beat", beat_count, 64'd40);
        checkOutput("t1_byte", byte_count, 64'd2560);
        checkOutput("t1_errcnt", 64'(err_count), 64'd0);
        checkOutput("t1_flags", 64'({err_seq, err_keep, err_len}), 64'd0);

        $display("[TB] test 2: alternating tready");
        cfg_ready_pattern = 8'b0101_0101;
        repeat (3) @(negedge clk);
        highs   = 0;
        toggles = 0;
        prev    = s_axis_tready;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (s_axis_tready) highs++;
            if (s_axis_tready != prev) toggles++;
            prev = s_axis_tready;
        end
        checkOutput("t2_ready_highs", 64'(highs), 64'd8);
        checkOutput("t2_ready_toggles", 64'(toggles), 64'd16);
        for (int p = 0; p < 10; p++) sendPkt(64'd2, 3);
        @(negedge clk);
        checkOutput("t2_pkt", pkt_count, 64'd20);
        checkOutput("t2_beat", beat_count, 64'd80);
        checkOutput("t2_byte", byte_count, 64'd5120);
        checkOutput("t2_errcnt", 64'(err_count), 64'd0);
        cfg_ready_pattern = 8'hFF;

        $display("[TB] tests 3-4: table of sequence, keep and length cases");
        vecs.push_back(v(HDR,  ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(2,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(3,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(9,    ONES,  1, 0, 1, 1, 0, 0, 1, 21));
        vecs.push_back(v(HDR,  ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(5,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(6,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(7,    ONES,  1, 0, 1, 1, 0, 0, 1, 22));
        vecs.push_back(v(HDR,  ONES,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(2,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(3,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(4,    K0F,   1, 0, 1, 0, 1, 0, 1, 23));
        vecs.push_back(v(HDR,  ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(2,    K0FF,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(3,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(4,    ONES,  1, 0, 1, 0, 1, 0, 2, 24));
        vecs.push_back(v(HDR,  ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(2,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(3,    ONES,  1, 0, 1, 0, 1, 1, 3, 25));
        vecs.push_back(v(HDR,  ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(2,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(3,    ONES,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(4,    KLOW8, 1, 0, 1, 0, 1, 1, 3, 26));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chk) begin
                @(negedge clk);
                checkOutput($sformatf("row%0d_err_seq", i), 64'(err_seq), 64'(vecs[i].e_seq));
                checkOutput($sformatf("row%0d_err_keep", i), 64'(err_keep), 64'(vecs[i].e_keep));
                checkOutput($sformatf("row%0d_err_len", i), 64'(err_len), 64'(vecs[i].e_len));
                checkOutput($sformatf("row%0d_err_count", i), 64'(err_count), 64'(vecs[i].e_cnt));
                checkOutput($sformatf("row%0d_pkt", i), pkt_count, vecs[i].e_pkt);
            end
        end
        checkStats("table");

        $display("[TB] test 5: overrun and drain");
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        checkOutput("t5_cleared", 64'({err_seq, err_keep, err_len}), 64'd0);
        sendPkt(64'd2, 11);
        @(negedge clk);
        checkOutput("t5_err_len", 64'(err_len), 64'd1);
        checkOutput("t5_err_seq", 64'(err_seq), 64'd0);
        checkOutput("t5_err_keep", 64'(err_keep), 64'd0);
        checkOutput("t5_errcnt", 64'(err_count), 64'd1);
        checkOutput("t5_pkt", pkt_count, 64'd27);
        checkStats("t5_drain");

        sendBeat(HDR, ONES, 1'b0, 1'b0);
        sendBeat(64'd40, ONES, 1'b0, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        highs  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_axis_tready) highs++;
        end
        checkOutput("t5_paused_ready", 64'(highs), 64'd0);
        enable = 1'b1;
        sendBeat(64'd41, ONES, 1'b0, 1'b0);
        sendBeat(64'd42, ONES, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_clean_errcnt", 64'(err_count), 64'd1);
        checkOutput("t5_clean_seq", 64'(err_seq), 64'd0);
        checkOutput("t5_clean_pkt", pkt_count, 64'd28);
        checkStats("t5_clean");

        $display("[TB] test 6: reset mid-packet and clear/error collision");
        sendBeat(HDR, ONES, 1'b0, 1'b0);
        sendBeat(64'd2, ONES, 1'b0, 1'b0);
        @(negedge clk);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6_rst_pkt", pkt_count, 64'd0);
        checkOutput("t6_rst_beat", beat_count, 64'd0);
        checkOutput("t6_rst_byte", byte_count, 64'd0);
        checkOutput("t6_rst_errcnt", 64'(err_count), 64'd0);
        checkOutput("t6_rst_tready", 64'(s_axis_tready), 64'd0);
        aresetn   = 1'b1;
        exp_beats = 0;
        exp_bytes = 0;
        sendPkt(64'd100, 3);
        @(negedge clk);
        checkOutput("t6_pkt", pkt_count, 64'd1);
        checkOutput("t6_errcnt", 64'(err_count), 64'd0);
        checkOutput("t6_flags", 64'({err_seq, err_keep, err_len}), 64'd0);
        checkStats("t6");

        sendPkt(64'd2, 2);
        @(negedge clk);
        checkOutput("t6_len_flag", 64'(err_len), 64'd1);
        checkOutput("t6_len_errcnt", 64'(err_count), 64'd1);
        sendBeat(HDR, ONES, 1'b0, 1'b0);
        sendBeat(64'd2, ONES, 1'b0, 1'b0);
        sendBeat(64'd3, ONES, 1'b0, 1'b0);
        sendBeat(64'd9, ONES, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t6_clr_seq", 64'(err_seq), 64'd1);
        checkOutput("t6_clr_len", 64'(err_len), 64'd0);
        checkOutput("t6_clr_errcnt", 64'(err_count), 64'd1);
        checkOutput("t6_clr_pkt", pkt_count, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
